disp_share_ctrl: RTL
====================

// Module: disp_share_ctrl
// PURPOSE
//   Time-shares the 4-digit hex display driver among 4 requesters.
//   Each requester raises req[i] with its own hexs/points/les.
//   A round-robin scheduler grants the display to one requester for at least DWELL cycles.
//   The granted source's fields are registered onto the driver inputs: hexs[15:0], points[3:0], les[3:0].
//   The block sits between application logic and the 4-digit driver.
// PARAMETERS
//   DWELL  16  minimum grant length in clk cycles before rotation under contention (>=1)
//   CNT_W  4   timer width; must satisfy 2**CNT_W >= DWELL
// PORTS
//   clk          in   1   system clock, all logic on rising edge
//   rst          in   1   asynchronous, active-high reset
//   req          in   4   req[i]=1: requester i wants the display
//   hexs_bus     in   64  requester i digits at [16*i+15:16*i]; leftmost digit in the top nibble
//   points_bus   in   16  requester i points at [4*i+3:4*i]; 1 = point lit
//   les_bus      in   16  requester i digit enables at [4*i+3:4*i]; 0 = digit on
//   grant        out  4   one-hot owner; 4'b0000 when idle
//   hexs         out  16  to driver hexs
//   points       out  4   to driver points
//   les          out  4   to driver les; 4'hF blanks all digits
//   switched     out  1   1-cycle pulse on any edge where grant changes to a new nonzero owner
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, grant=0, owner=0, ptr=0, timer=0.
//     Outputs during reset: hexs=0, points=0, les=4'hF, switched=0.
//   Round-robin pick: first i with req[i]=1, searching ptr, ptr+1, ... (mod 4).
//     On every grant to i: ptr <= (i+1) mod 4, timer <= 0.
//   IDLE: if req!=0, then next edge: state=SHOW, grant=onehot(pick), switched=1.
//     In the same edge, outputs load that owner's fields.
//   IDLE with req==0: outputs stay hexs=0, points=0, les=4'hF.
//   SHOW, every edge: hexs/points/les <= current fields of owner (live, 1-cycle latency).
//     timer increments, saturating at DWELL-1.
//   SHOW rotation: timer==DWELL-1 and another req pending -> grant next RR requester on that edge.
//     The new owner's data is loaded on that edge. There is no blank gap; switched=1.
//   SHOW, timer==DWELL-1, no other req: keep owner, timer holds, switched=0.
//   Owner drops req (any timer value), others pending -> switch to RR pick next edge.
//   Owner drops req, none pending -> next edge: IDLE, grant=0, les=4'hF, hexs=0, points=0.
//   Owner drop and timer expiry in the same cycle: the owner-drop rule applies.
//   New requests mid-dwell are not preemptive; they wait for expiry or owner drop.
//   DWELL=1: rotation is possible on every edge under contention.
//   grant is always one-hot or zero. grant!=0 if and only if state==SHOW.
//   Reset asserted mid-grant: everything returns to reset values immediately, without waiting for clk.
// TESTING (DWELL=4)
//   Reset applied with req=4'hF -> grant=0, les=4'hF.
//     After rst falls: grant=0001 one edge later, switched=1 for 1 cycle.
//   Single requester: req=0100, hexs_bus[47:32]=16'h1234 -> grant=0100, hexs=1234.
//     Held indefinitely; switched stays 0 after the first pulse.
//   Contention: req=1111 -> owners 0,1,2,3,0 in order, each exactly 4 cycles.
//     No cycle with les=4'hF between owners.
//   Early drop: owner 1 drops req at timer=1 with req[3]=1 -> grant=1000 next edge.
//   Owner 2 drops req, req becomes 0 -> next edge grant=0, les=4'hF, hexs=0.
//   Live data: owner 0 changes hexs 16'hABCD->16'h0001 mid-dwell -> hexs follows one edge later.
//     Owner unchanged.
//   Async reset pulse mid-dwell, between clk edges -> outputs reach reset values without a clk edge.

Source files
------------

// File: rtl/disp_share_ctrl.sv
// disp_share_ctrl: round-robin time-sharing of a 4-digit hex display driver
// among 4 requesters, with a minimum dwell per grant under contention.
module disp_share_ctrl #(
  parameter int unsigned DWELL = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] hexs_bus,
  input  logic [15:0] points_bus,
  input  logic [15:0] les_bus,
  output logic [3:0]  grant,
  output logic [15:0] hexs,
  output logic [3:0]  points,
  output logic [3:0]  les,
  output logic        switched
);

  localparam int unsigned NREQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [3:0]         grant_q, grant_d;
  logic [15:0]        hexs_q, hexs_d;
  logic [3:0]         points_q, points_d;
  logic [3:0]         les_q, les_d;
  logic               switched_q, switched_d;

  logic [1:0]         pick_c;
  logic               pick_vld_c;
  logic               own_req_c;
  logic               other_c;
  logic               expire_c;

  // Round-robin pick: first requester at or after ptr (lowest offset wins).
  always_comb begin
    logic [1:0] idx;
    pick_c     = ptr_q;
    pick_vld_c = 1'b0;
    idx        = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) begin
        pick_c     = idx;
        pick_vld_c = 1'b1;
      end
    end
  end

  assign own_req_c = req[owner_q];
  assign other_c   = |(req & ~grant_q);
  assign expire_c  = (timer_q == CNT_W'(DWELL - 1));

  // Next-state and registered-output logic.
  always_comb begin
    logic       do_grant;
    logic       do_load;
    logic [1:0] sel;
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    grant_d    = grant_q;
    hexs_d     = 16'h0000;
    points_d   = 4'h0;
    les_d      = 4'hF;
    switched_d = 1'b0;
    do_grant   = 1'b0;
    do_load    = 1'b0;
    sel        = owner_q;

    case (state_q)
      IDLE: begin
        if (pick_vld_c) do_grant = 1'b1;
      end
      SHOW: begin
        if (!own_req_c) begin
          // Owner released: hand over or fall back to idle.
          if (pick_vld_c) begin
            do_grant = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = 4'h0;
          end
        end else if (expire_c && other_c) begin
          do_grant = 1'b1;
        end else begin
          do_load = 1'b1;
          if (!expire_c) timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'h0;
      end
    endcase

    if (do_grant) begin
      state_d    = SHOW;
      owner_d    = pick_c;
      ptr_d      = pick_c + 2'd1;
      timer_d    = '0;
      grant_d    = 4'(1) << pick_c;
      switched_d = 1'b1;
      do_load    = 1'b1;
      sel        = pick_c;
    end

    if (do_load) begin
      hexs_d   = hexs_bus[{sel, 4'b0000} +: 16];
      points_d = points_bus[{sel, 2'b00} +: 4];
      les_d    = les_bus[{sel, 2'b00} +: 4];
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      ptr_q      <= 2'd0;
      timer_q    <= '0;
      grant_q    <= 4'h0;
      hexs_q     <= 16'h0000;
      points_q   <= 4'h0;
      les_q      <= 4'hF;
      switched_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      grant_q    <= grant_d;
      hexs_q     <= hexs_d;
      points_q   <= points_d;
      les_q      <= les_d;
      switched_q <= switched_d;
    end
  end

  assign grant    = grant_q;
  assign hexs     = hexs_q;
  assign points   = points_q;
  assign les      = les_q;
  assign switched = switched_q;

endmodule
